cby_cfg_param: RTL and testbench

CBY_CFG_PARAM -- requirements
Module: cby_cfg_param

---
 rtl/cby_cfg_param.sv | 124 ++++++++++++
 tb/tb_cby_cfg_param.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cby_cfg_param.sv
// Y-direction connection block: tracks pass straight through, and per-ipin muxes pick a track.
// Mux selects come from a serial shadow frame that is committed atomically into the active config.
module cby_cfg_param #(
  parameter int unsigned CHAN_WIDTH   = 20,
  parameter int unsigned NUM_IPIN     = 4,
  parameter int unsigned MUX_SIZE     = 10,
  parameter int unsigned TRACK_STRIDE = 4,
  parameter int unsigned REG_OUT      = 0
) (
  input  logic                  prog_clk,
  input  logic                  prog_reset,
  input  logic [CHAN_WIDTH-1:0] chany_bottom_in,
  input  logic [CHAN_WIDTH-1:0] chany_top_in,
  input  logic                  ccff_head,
  input  logic                  ccff_en,
  input  logic                  ccff_commit,
  output logic [CHAN_WIDTH-1:0] chany_bottom_out,
  output logic [CHAN_WIDTH-1:0] chany_top_out,
  output logic [NUM_IPIN-1:0]   ipin_out,
  output logic                  ccff_tail,
  output logic                  cfg_loaded,
  output logic                  commit_err,
  output logic [NUM_IPIN-1:0]   sel_err
);

  localparam int unsigned SEL_W = (MUX_SIZE > 1) ? $clog2(MUX_SIZE) : 1;
  localparam int unsigned TOTAL = NUM_IPIN * SEL_W;
  localparam int unsigned CNT_W = $clog2(TOTAL + 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(TOTAL);
  localparam logic [SEL_W:0]   SEL_LIMIT = (SEL_W + 1)'(MUX_SIZE);

  logic [TOTAL-1:0]    shadow_q, shadow_d;
  logic [TOTAL-1:0]    active_q, active_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                commit_err_q, commit_err_d;
  logic [NUM_IPIN-1:0] ipin_c;

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      shadow_q     <= '0;
      active_q     <= '0;
      cnt_q        <= '0;
      commit_err_q <= 1'b0;
    end else begin
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      cnt_q        <= cnt_d;
      commit_err_q <= commit_err_d;
    end
  end

  // Commit samples the pre-edge shadow, so a shift in the same cycle starts the next frame.
  always_comb begin
    shadow_d     = shadow_q;
    active_d     = active_q;
    cnt_d        = cnt_q;
    commit_err_d = commit_err_q;
    if (ccff_en) begin
      shadow_d = TOTAL'({shadow_q, ccff_head});
      if (cnt_q != CNT_FULL) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    if (ccff_commit) begin
      if (cnt_q == CNT_FULL) begin
        active_d = shadow_q;
        cnt_d    = ccff_en ? CNT_W'(1) : '0;
      end else begin
        commit_err_d = 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NUM_IPIN; k++) begin : g_ipin
    logic [MUX_SIZE-1:0] mux_in;
    logic [SEL_W-1:0]    sel;
    logic                pick;

    assign sel = active_q[k*SEL_W +: SEL_W];

    // Input pairs (bottom, top) walk the channel in TRACK_STRIDE steps, wrapping.
    for (genvar j = 0; j < MUX_SIZE; j++) begin : g_in
      localparam int unsigned TRK = (k + (j / 2) * TRACK_STRIDE) % CHAN_WIDTH;
      if (j % 2 == 0) begin : g_bot
        assign mux_in[j] = chany_bottom_in[TRK];
      end else begin : g_top
        assign mux_in[j] = chany_top_in[TRK];
      end
    end

    always_comb begin
      pick = 1'b0;
      for (int j = 0; j < MUX_SIZE; j++) begin
        if (sel == SEL_W'(j)) begin
          pick = mux_in[j];
        end
      end
    end

    assign ipin_c[k]  = pick;
    assign sel_err[k] = ({1'b0, sel} >= SEL_LIMIT);
  end

  if (REG_OUT != 0) begin : g_reg_out
    logic [NUM_IPIN-1:0] ipin_q;
    always_ff @(posedge prog_clk) begin
      if (prog_reset) begin
        ipin_q <= '0;
      end else begin
        ipin_q <= ipin_c;
      end
    end
    assign ipin_out = ipin_q;
  end else begin : g_comb_out
    assign ipin_out = ipin_c;
  end

  assign chany_bottom_out = chany_top_in;
  assign chany_top_out    = chany_bottom_in;
  assign ccff_tail        = shadow_q[TOTAL-1];
  assign cfg_loaded       = (cnt_q == CNT_FULL);
  assign commit_err       = commit_err_q;

endmodule

// File: tb/tb_cby_cfg_param.sv
// Bench for cby_cfg_param: default instance (A) plus a small registered-output instance (B),
// both compared every cycle against a bit-history / decoded-select reference model.
module tb_cby_cfg_param;

  logic prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  logic rst [2];
  logic head[2];
  logic en  [2];
  logic cmt [2];

  logic [19:0] bot_a, top_a, bo_a, to_a;
  logic [3:0]  ip_a, se_a;
  logic        tail_a, ld_a, ce_a;
  logic [7:0]  bot_b, top_b, bo_b, to_b;
  logic [1:0]  ip_b, se_b;
  logic        tail_b, ld_b, ce_b;

  cby_cfg_param u_dut_a (
    .prog_clk(prog_clk), .prog_reset(rst[0]),
    .chany_bottom_in(bot_a), .chany_top_in(top_a),
    .ccff_head(head[0]), .ccff_en(en[0]), .ccff_commit(cmt[0]),
    .chany_bottom_out(bo_a), .chany_top_out(to_a),
    .ipin_out(ip_a), .ccff_tail(tail_a), .cfg_loaded(ld_a),
    .commit_err(ce_a), .sel_err(se_a)
  );

  cby_cfg_param #(.CHAN_WIDTH(8), .NUM_IPIN(2), .MUX_SIZE(4), .TRACK_STRIDE(4), .REG_OUT(1)) u_dut_b (
    .prog_clk(prog_clk), .prog_reset(rst[1]),
    .chany_bottom_in(bot_b), .chany_top_in(top_b),
    .ccff_head(head[1]), .ccff_en(en[1]), .ccff_commit(cmt[1]),
    .chany_bottom_out(bo_b), .chany_top_out(to_b),
    .ipin_out(ip_b), .ccff_tail(tail_b), .cfg_loaded(ld_b),
    .commit_err(ce_b), .sel_err(se_b)
  );

  // Reference model: per instance geometry, shifted-bit history (index 0 = newest), decoded selects.
  int cw_m[2] = '{20, 8};
  int ni_m[2] = '{4, 2};
  int ms_m[2] = '{10, 4};
  int sw_m[2] = '{4, 2};
  int st_m[2] = '{4, 4};
  bit       recent[2][16];
  int       cnt_m [2];
  int       sel_m [2][4];
  bit       cerr_m[2];
  bit [3:0] reg_m [2];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit trk(input int d, input bit from_top, input int t);
    if (d == 0) return from_top ? top_a[t] : bot_a[t];
    return from_top ? top_b[t] : bot_b[t];
  endfunction

  function automatic bit [3:0] exp_vec(input int d);
    bit [3:0] v = '0;
    for (int k = 0; k < ni_m[d]; k++) begin
      int s = sel_m[d][k];
      if (s < ms_m[d]) v[k] = trk(d, (s % 2) == 1, (k + (s / 2) * st_m[d]) % cw_m[d]);
    end
    return v;
  endfunction

  function automatic bit [3:0] exp_serr(input int d);
    bit [3:0] v = '0;
    for (int k = 0; k < ni_m[d]; k++) v[k] = (sel_m[d][k] >= ms_m[d]);
    return v;
  endfunction

  task automatic model_edge(input int d);
    int tot = ni_m[d] * sw_m[d];
    if (rst[d]) begin
      for (int i = 0; i < 16; i++) recent[d][i] = 1'b0;
      for (int k = 0; k < 4; k++) sel_m[d][k] = 0;
      cnt_m[d] = 0; cerr_m[d] = 1'b0; reg_m[d] = '0;
      return;
    end
    reg_m[d] = exp_vec(d);
    if (cmt[d] && cnt_m[d] == tot) begin
      // Oldest bit of the frame is the MSB of the highest ipin's select.
      for (int k = 0; k < ni_m[d]; k++) begin
        int s = 0;
        for (int b = 0; b < sw_m[d]; b++)
          s = s * 2 + int'(recent[d][tot - 1 - ((ni_m[d] - 1 - k) * sw_m[d] + b)]);
        sel_m[d][k] = s;
      end
      cnt_m[d] = en[d] ? 1 : 0;
    end else begin
      if (cmt[d]) cerr_m[d] = 1'b1;
      if (en[d] && cnt_m[d] < tot) cnt_m[d]++;
    end
    if (en[d]) begin
      for (int i = 15; i > 0; i--) recent[d][i] = recent[d][i-1];
      recent[d][0] = head[d];
    end
  endtask

  task automatic check_all();
    chk("a_pass_bot", bo_a, top_a);
    chk("a_pass_top", to_a, bot_a);
    chk("a_tail", tail_a, recent[0][15]);
    chk("a_loaded", ld_a, cnt_m[0] == 16);
    chk("a_cerr", ce_a, cerr_m[0]);
    chk("a_selerr", se_a, exp_serr(0));
    chk("a_ipin", ip_a, exp_vec(0));
    chk("b_pass_bot", bo_b, top_b);
    chk("b_pass_top", to_b, bot_b);
    chk("b_tail", tail_b, recent[1][3]);
    chk("b_loaded", ld_b, cnt_m[1] == 4);
    chk("b_cerr", ce_b, cerr_m[1]);
    chk("b_selerr", se_b, exp_serr(1) & 4'h3);
    chk("b_ipin", ip_b, reg_m[1]);
  endtask

  // Called just after an edge: new tracks, mid-cycle check, then the next edge.
  task automatic tick();
    bot_a = 20'($urandom); top_a = 20'($urandom);
    bot_b = 8'($urandom);  top_b = 8'($urandom);
    #2 check_all();
    @(posedge prog_clk);
    model_edge(0);
    model_edge(1);
    #1;
  endtask

  task automatic set_in(input int d, input bit r, input bit h, input bit e, input bit c);
    rst[d] = r; head[d] = h; en[d] = e; cmt[d] = c;
  endtask

  task automatic shift_bits(input int d, input int val, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      set_in(d, 1'b0, val[i], 1'b1, 1'b0);
      tick();
    end
    set_in(d, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic commit(input int d);
    set_in(d, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    set_in(d, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic reset_dut(input int d);
    set_in(d, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(d, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bot_a = '0; top_a = '0; bot_b = '0; top_b = '0;
    for (int d = 0; d < 2; d++) set_in(d, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge prog_clk);
    model_edge(0);
    model_edge(1);
    #1;
    for (int d = 0; d < 2; d++) set_in(d, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("rst_ipin_a", ip_a, bot_a[3:0]);
    chk("rst_tail_a", tail_a, 1'b0);

    // Selects {9,0,5,2} MSB-first.
    shift_bits(0, 32'h9052, 16);
    chk("r35_loaded", ld_a, 1'b1);
    commit(0);
    chk("r35_ip0", ip_a[0], bot_a[4]);
    chk("r35_ip1", ip_a[1], top_a[9]);
    chk("r35_ip2", ip_a[2], bot_a[2]);
    chk("r35_ip3", ip_a[3], top_a[19]);
    tick(); tick();

    // Second frame shifted without commit: old config holds, first frame drains out of the tail.
    shift_bits(0, 32'h1234, 16);
    chk("r39_ip0", ip_a[0], bot_a[4]);

    // Commit together with a shift at a full count.
    set_in(0, 1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    set_in(0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("r38_loaded", ld_a, 1'b0);
    shift_bits(0, 32'h7fff, 15);
    chk("r38_full", ld_a, 1'b1);

    // Out-of-range select on ipin0.
    shift_bits(0, 32'h000C, 16);
    commit(0);
    chk("r37_selerr", se_a[0], 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("r37_ip0", ip_a[0], 1'b0);
    end

    // Premature commit is sticky until reset.
    reset_dut(0);
    shift_bits(0, 32'h2ABCD, 10);
    commit(0);
    chk("r36_cerr", ce_a, 1'b1);
    chk("r36_ipin", ip_a, bot_a[3:0]);
    shift_bits(0, 32'h5, 6);
    commit(0);
    chk("r36_sticky", ce_a, 1'b1);
    reset_dut(0);
    chk("r36_clear", ce_a, 1'b0);

    // Registered-output instance: selects {3,2}, then a reset mid-shift.
    shift_bits(1, 32'hE, 4);
    commit(1);
    for (int i = 0; i < 6; i++) tick();
    shift_bits(1, 32'h3, 2);
    reset_dut(1);
    chk("r40_loaded", ld_b, 1'b0);
    chk("r40_ipin", ip_b, 2'b00);
    chk("r40_tail", tail_b, 1'b0);
    shift_bits(1, 32'h7, 3);
    commit(1);
    chk("r40_partial", ce_b, 1'b1);
    reset_dut(1);

    // Random traffic on both instances.
    for (int i = 0; i < 800; i++) begin
      for (int d = 0; d < 2; d++)
        set_in(d, ($urandom % 150) == 0, 1'($urandom), ($urandom % 4) != 0, ($urandom % 10) == 0);
      tick();
    end
    for (int d = 0; d < 2; d++) set_in(d, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
